// File: rtl/regfile_n.sv
// Multi-register file with 2 registered read ports, 1 write port, per-register written flags. Read latency 1 cycle; no backpressure.
// Optional write-to-read forwarding with REGFILE_BYPASS_EN. CLR is synchronous and active-high, and overrides both writes and bypass.
module regfile_n #(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              CLR,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WA,
    input  logic [WIDTH-1:0]  WD,
    input  logic [ADDR_W-1:0] RA1,
    input  logic [ADDR_W-1:0] RA2,
    output logic [WIDTH-1:0]  RD1,
    output logic [WIDTH-1:0]  RD2,
    output logic [DEPTH-1:0]  VALID
);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] wr_sel;
    logic [WIDTH-1:0] rd1_q, rd1_d;
    logic [WIDTH-1:0] rd2_q, rd2_d;

    always_comb begin
        wr_sel = '0;
        if (WE) begin
            wr_sel[WA] = 1'b1;
        end
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = wr_sel[i] ? WD : regs_q[i];
        end
        valid_d = valid_q | wr_sel;
        // Reads see pre-write contents unless forwarding is compiled in.
        rd1_d = regs_q[RA1];
        rd2_d = regs_q[RA2];
`ifdef REGFILE_BYPASS_EN
        if (WE && (RA1 == WA)) begin
            rd1_d = WD;
        end
        if (WE && (RA2 == WA)) begin
            rd2_d = WD;
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (CLR) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            valid_q <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
        end else begin
            regs_q  <= regs_d;
            valid_q <= valid_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
        end
    end

    assign RD1   = rd1_q;
    assign RD2   = rd2_q;
    assign VALID = valid_q;

endmodule
